// File: rtl/apb_cmd_master_if.sv
// Command/response streams plus the APB3 initiator signals of apb_cmd_master.
// The master modport is the initiator's view; slave is the command source, response sink and APB responder.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 10
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command in, one APB transfer out, one response back.
// ACCESS waits are bounded by TIMEOUT (0 = unbounded); an abort returns rsp_err with zero data.
module apb_cmd_master #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_cmd_master_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e            state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [31:0]       pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  always_comb begin
    // NOTE: every *_d defaults to its *_q first so no path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : 32'd0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PREADY is tested first so a completion on the timeout cycle still wins.
        if (bus.PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'd0 : bus.PRDATA;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_C)) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values; reset is synchronous.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: a driver issues commands and pushes model results,
// an APB responder process plays the peripheral, and a monitor pops and compares responses.
module tb_apb_cmd_master;

  localparam int TO = 4;

  typedef struct {
    bit          write;
    logic [9:0]  addr;
    logic [31:0] pwdata;
    int          w;
    logic [31:0] rdata;
    int          acc_cyc;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  int   cyc    = 0;

  int n_checks = 0;
  int n_errors = 0;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    last_hs_cyc = -100;
  int    bp_cycles   = 0;

  apb_cmd_master_if #(.ADDR_W(10)) bus ();

  apb_cmd_master #(
    .ADDR_W (10),
    .TIMEOUT(TO),
    .CNT_W  (8)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus.master)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transfer-level reference: the responder answers after w wait cycles; more than TO waits aborts.
  function automatic exp_t model(input bit wr, input int w, input logic [31:0] prdata, input int acc);
    exp_t e;
    e.err     = (w > TO);
    e.rdata   = (wr || e.err) ? 32'd0 : prdata;
    e.lat     = 2 + (e.err ? TO : w);
    e.acc_cyc = acc;
    return e;
  endfunction

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send_cmd(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                          input int w, input logic [31:0] prdata, input bit b2b);
    int    budget;
    int    acc;
    plan_t p;
    budget        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready) begin
      @(negedge PCLK);
      budget++;
      if (budget > 200) begin
        check("cmd_accept_timeout", 64'd0, 64'd1);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    acc       = cyc + 1;
    p.write   = wr;
    p.addr    = addr;
    p.pwdata  = wr ? wd : 32'd0;
    p.w       = w;
    p.rdata   = prdata;
    p.acc_cyc = acc;
    plan_q.push_back(p);
    exp_q.push_back(model(wr, w, prdata, acc));
    if (b2b) check("b2b_spacing", 64'(acc), 64'(last_hs_cyc + 1));
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 || !bus.cmd_ready) begin
      @(negedge PCLK);
      budget++;
      if (budget > 500) begin
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        return;
      end
    end
  endtask

  // APB responder: inserts the planned wait states, otherwise drives junk PREADY/PRDATA.
  initial begin
    plan_t cur;
    bit    active;
    int    k;
    active     = 1'b0;
    k          = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'd0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        active     = 1'b0;
        bus.PREADY = 1'b0;
        continue;
      end
      if (bus.PSEL && !bus.PENABLE) begin
        if (plan_q.size() == 0) begin
          check("setup_without_cmd", 64'd1, 64'd0);
        end else begin
          cur    = plan_q.pop_front();
          active = 1'b1;
          k      = 0;
          check("setup_latency", 64'(cyc - cur.acc_cyc), 64'd0);
          check("setup_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {cur.write, cur.addr, cur.pwdata});
        end
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end else if (bus.PSEL && bus.PENABLE && active) begin
        check("access_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {cur.write, cur.addr, cur.pwdata});
        bus.PREADY = (k == cur.w);
        bus.PRDATA = (k == cur.w) ? cur.rdata : $urandom;
        k++;
      end else begin
        if (!bus.PSEL) active = 1'b0;
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end
    end
  end

  // Response monitor and sink: owns rsp_ready, pops the scoreboard on each new response.
  initial begin
    exp_t cur;
    bit   in_rsp;
    bit   rdy;
    bit   ok;
    int   hold;
    in_rsp        = 1'b0;
    hold          = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        in_rsp        = 1'b0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      ok = !(bus.PENABLE && !bus.PSEL) && !(bus.PSEL && bus.rsp_valid)
           && (bus.cmd_ready == !(bus.PSEL || bus.rsp_valid));
      check("bus_protocol", 64'(ok), 64'd1);
      if (bus.rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            check("spurious_rsp", 64'd1, 64'd0);
            bus.rsp_ready = 1'b1;
            continue;
          end
          cur    = exp_q.pop_front();
          in_rsp = 1'b1;
          hold   = bp_cycles;
          check("rsp_latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
        end
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(cur.rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(cur.err));
        if (hold > 0) begin
          rdy = 1'b0;
          hold--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        bus.rsp_ready = rdy;
        if (rdy) begin
          in_rsp      = 1'b0;
          last_hs_cyc = cyc + 1;
        end
      end else begin
        if (in_rsp) begin
          check("rsp_dropped", 64'd0, 64'd1);
          in_rsp = 1'b0;
        end
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 32'd0;

    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    check("reset_psel",      64'(bus.PSEL),      64'd0);
    check("reset_penable",   64'(bus.PENABLE),   64'd0);
    check("reset_pwrite",    64'(bus.PWRITE),    64'd0);
    check("reset_paddr",     64'(bus.PADDR),     64'd0);
    check("reset_pwdata",    64'(bus.PWDATA),    64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Directed: zero-wait write, 3-wait read, timeout, PREADY on the timeout cycle.
    send_cmd(1'b1, 10'h004, 32'h0000_0010, 0, 32'hDEAD_BEEF, 1'b0);
    wait_drain();
    send_cmd(1'b0, 10'h002, 32'hFFFF_FFFF, 3, 32'h0000_007F, 1'b0);
    wait_drain();
    send_cmd(1'b0, 10'h0AA, 32'h0,         TO + 1, 32'h1111_1111, 1'b0);
    wait_drain();
    send_cmd(1'b0, 10'h3FF, 32'h0,         TO, 32'h0000_00A5, 1'b0);
    wait_drain();

    // Response backpressure with a second read queued behind the first.
    bp_cycles = 5;
    send_cmd(1'b0, 10'h010, 32'h0, 1, 32'hCAFE_0001, 1'b0);
    send_cmd(1'b0, 10'h011, 32'h0, 0, 32'hCAFE_0002, 1'b1);
    wait_drain();
    bp_cycles = 0;

    // Reset pulse during ACCESS; the pending response must vanish.
    send_cmd(1'b0, 10'h155, 32'h0, TO + 4, 32'h1234_5678, 1'b0);
    budget = 0;
    while (!(bus.PSEL && bus.PENABLE) && budget < 10) begin
      @(negedge PCLK);
      budget++;
    end
    check("reached_access", 64'(bus.PSEL && bus.PENABLE), 64'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    exp_q.delete();
    plan_q.delete();
    check("midreset_psel",      64'(bus.PSEL),      64'd0);
    check("midreset_penable",   64'(bus.PENABLE),   64'd0);
    check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midreset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(1'b1, 10'h2C3, 32'h8765_4321, 2, 32'h0, 1'b0);
    wait_drain();

    // Randomised traffic, wait counts straddling the timeout.
    for (int i = 0; i < 150; i++) begin
      send_cmd(1'($urandom_range(0, 1)), 10'($urandom), $urandom,
               int'($urandom_range(0, TO + 2)), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    wait_drain();
    repeat (4) @(negedge PCLK);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("plan_empty",       64'(plan_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
